magnetron_pwm_ctrl: RTL and testbench
=====================================

MAGNETRON_PWM_CTRL -- requirements
Module: magnetron_pwm_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 1000, meaning clock cycles per one-second tick (>=2).
REQ-002 The block SHALL have parameter TIME_W, default 10, meaning countdown width in seconds.
REQ-003 The block SHALL have parameter PWR_LEVELS, default 10, meaning power steps and PWM period in ticks (>=2).
REQ-004 The block SHALL have a single clock, clk, input, 1 bit, with all state updated on its rising edge.
REQ-005 The block SHALL have rst, input, 1 bit, a synchronous active-high reset.
REQ-006 The block SHALL have inputs startn, stopn and clearn, each 1 bit, active-low level buttons already synchronised to clk.
REQ-007 The block SHALL have door_closed, input, 1 bit, high when the door is shut.
REQ-008 The block SHALL have time_load, input, TIME_W bits, giving the cook time in seconds.
REQ-009 The block SHALL have time_load_en, input, 1 bit, a one-cycle load strobe.
REQ-010 The block SHALL have power_level, input, PW=$clog2(PWR_LEVELS+1) bits, giving the on-ticks per PWM period.
REQ-011 The block SHALL have mag_on, output, 1 bit, the magnetron enable.
REQ-012 The block SHALL have time_left, output, TIME_W bits, giving the remaining seconds.
REQ-013 The block SHALL have state, output, 3 bits, the current FSM state encoding.
REQ-014 The block SHALL have done, output, 1 bit, a one-cycle completion pulse.
REQ-015 The block SHALL have beep, output, 1 bit, the completion beeper.

Function
REQ-016 Buttons SHALL be registered; a press is the 1->0 edge of the registered value; one press gives one event.
REQ-017 Simultaneous presses SHALL be prioritised as clear > stop > start.
REQ-018 FSM states SHALL be IDLE=0, COOK=1, PAUSED=2, DONE=3.
REQ-019 In IDLE or PAUSED, time_load_en SHALL load time_left<=time_load on the next edge; in COOK and DONE it SHALL be ignored.
REQ-020 IDLE->COOK and PAUSED->COOK SHALL occur on a start press only if door_closed=1 and time_left!=0; otherwise start SHALL be ignored.
REQ-021 power_level SHALL be latched on each entry to COOK; latched values above PWR_LEVELS SHALL saturate to PWR_LEVELS.
REQ-022 COOK->PAUSED SHALL occur on a stop press or when door_closed=0 (next edge).
REQ-023 A stop press in PAUSED SHALL go to IDLE with time_left<=0.
REQ-024 A clear press SHALL, from any state, go to IDLE with time_left<=0.
REQ-025 The prescaler SHALL count 0..TICK_DIV-1 only in COOK, pulsing tick when at TICK_DIV-1, and SHALL be held at 0 outside COOK (partial seconds are discarded on pause).
REQ-026 On tick in COOK, time_left SHALL decrement; on a tick with time_left==1 the block SHALL set time_left to 0, go to DONE, and assert done for exactly one cycle.
REQ-027 The PWM phase counter SHALL count 0..PWR_LEVELS-1, advance on tick and wrap, and reset to 0 on each entry to COOK.
REQ-028 mag_on SHALL be combinational: (state==COOK) & door_closed & (phase < latched_power); door opening SHALL drop mag_on in the same cycle.
REQ-029 A latched power of 0 SHALL keep mag_on=0, while the countdown still runs.
REQ-030 DONE->IDLE SHALL occur on any button press or when door_closed=0.
REQ-031 A tick coinciding with stop or door-open SHALL be discarded, and the transition to PAUSED SHALL win.

Reset
REQ-032 rst SHALL override all inputs.
REQ-033 After the rst edge the block SHALL have state=IDLE, time_left=0, mag_on=0, done=0, beep=0, prescaler=0, phase=0, latched power=0, and button registers=1.
REQ-034 Reset mid-COOK SHALL drop mag_on at that same edge.

Configuration
REQ-035 With MAGNETRON_BEEP_EN defined, beep SHALL assert on entry to DONE and stay high for 3 ticks or until DONE is left; in DONE the prescaler SHALL run.
REQ-036 Without MAGNETRON_BEEP_EN, beep SHALL be constant 0 and no beep counter SHALL exist.

Structure
REQ-037 Package mag_pkg SHALL hold the state typedef/encodings, the BEEP_TICKS=3 constant, and a PW width function.
REQ-038 Sub-module mag_tick_gen (parameter TICK_DIV; ports clk, rst, en, tick) SHALL implement the prescaler.

Verification (TICK_DIV=4, PWR_LEVELS=4, TIME_W=8)
REQ-039 Load 3, power 4, start, door closed -> mag_on high 12 cycles, time_left 3->2->1->0, one done pulse, state DONE.
REQ-040 Load 8, power 1, start -> mag_on high for 1 tick in every 4, repeating.
REQ-041 Opening the door mid-COOK -> mag_on 0 in the same cycle, PAUSED next edge, time_left frozen; closing the door plus start -> COOK resumes from the frozen value.
REQ-042 Stop then stop -> PAUSED then IDLE with time_left=0; start with time_left=0 or the door open -> state stays IDLE.
REQ-043 Simultaneous start+clear in PAUSED -> IDLE; rst asserted mid-COOK -> all outputs at their reset values after one edge.
REQ-044 With MAGNETRON_BEEP_EN: beep high 12 cycles after done; a button press at beep cycle 5 -> beep 0 and state IDLE next edge.

Source files
------------

// File: rtl/mag_pkg.sv
// Shared definitions for the magnetron PWM controller.
//   mag_state_t : FSM state encoding (also driven out on the 3-bit state port)
//   BEEP_TICKS  : length of the completion beep, in one-second ticks
//   pw_width()  : width of a power-level field able to hold 0..levels
package mag_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_COOK   = 3'd1,
    ST_PAUSED = 3'd2,
    ST_DONE   = 3'd3
  } mag_state_t;

  localparam int BEEP_TICKS = 3;

  function automatic int pw_width(input int levels);
    return $clog2(levels + 1);
  endfunction

endpackage

// File: rtl/mag_tick_gen.sv
// One-second prescaler. Counts 0..TICK_DIV-1 while en is high and pulses
// tick in the cycle the count sits at TICK_DIV-1. Dropping en clears the
// count, so any partial second is thrown away.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   en   : run enable
//   tick : one-cycle pulse once per TICK_DIV enabled cycles
module mag_tick_gen
  import mag_pkg::*;
#(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == CNT_LAST);

endmodule

// File: rtl/magnetron_pwm_ctrl.sv
// Microwave magnetron controller: cook-time countdown in seconds with a
// slow PWM (period PWR_LEVELS ticks) setting the average power.
// Optional feature macro: MAGNETRON_BEEP_EN -- completion beeper that runs
// for BEEP_TICKS seconds in DONE. Without it beep is tied low.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   startn, stopn, clearn   : active-low buttons, already synchronous to clk
//   door_closed             : high while the door is shut
//   time_load, time_load_en : cook time in seconds and its load strobe
//   power_level             : on-ticks per PWM period, latched on entry to COOK
//   mag_on                  : magnetron enable (combinational)
//   time_left               : remaining seconds
//   state                   : FSM state encoding
//   done                    : one-cycle pulse on reaching DONE
//   beep                    : completion beeper
//
// state  | meaning
// IDLE   | waiting; time may be loaded
// COOK   | counting down, magnetron driven by PWM
// PAUSED | stopped or door opened; time frozen, may be reloaded
// DONE   | countdown expired; beeper active if built in
module magnetron_pwm_ctrl
  import mag_pkg::*;
#(
  parameter int TICK_DIV   = 1000,
  parameter int TIME_W     = 10,
  parameter int PWR_LEVELS = 10,
  localparam int PW        = pw_width(PWR_LEVELS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              startn,
  input  logic              stopn,
  input  logic              clearn,
  input  logic              door_closed,
  input  logic [TIME_W-1:0] time_load,
  input  logic              time_load_en,
  input  logic [PW-1:0]     power_level,
  output logic              mag_on,
  output logic [TIME_W-1:0] time_left,
  output logic [2:0]        state,
  output logic              done,
  output logic              beep
);

  localparam logic [PW-1:0] PWR_MAX    = PW'(PWR_LEVELS);
  localparam logic [PW-1:0] PHASE_LAST = PW'(PWR_LEVELS - 1);

  mag_state_t        state_q, state_nxt;
  logic [TIME_W-1:0] time_q, time_nxt;
  logic [PW-1:0]     power_q;
  logic [PW-1:0]     phase_q, phase_nxt;
  logic              startn_q, stopn_q, clearn_q;
  logic              press_start, press_stop, press_clear;
  logic              cook_entry;
  logic              done_nxt;
  logic              tick, tick_en;

  // A press is the cycle where the registered copy is still high and the
  // input is low, i.e. the registered value falls at the coming edge.
  assign press_start = startn_q & ~startn;
  assign press_stop  = stopn_q  & ~stopn;
  assign press_clear = clearn_q & ~clearn;

  mag_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (tick_en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      time_q   <= '0;
      power_q  <= '0;
      phase_q  <= '0;
      done     <= 1'b0;
      startn_q <= 1'b1;
      stopn_q  <= 1'b1;
      clearn_q <= 1'b1;
    end else begin
      state_q  <= state_nxt;
      time_q   <= time_nxt;
      phase_q  <= phase_nxt;
      done     <= done_nxt;
      startn_q <= startn;
      stopn_q  <= stopn;
      clearn_q <= clearn;
      if (cook_entry) begin
        power_q <= (power_level > PWR_MAX) ? PWR_MAX : power_level;
      end
    end
  end

  always_comb begin
    state_nxt  = state_q;
    time_nxt   = time_q;
    phase_nxt  = phase_q;
    done_nxt   = 1'b0;
    cook_entry = 1'b0;

    if (press_clear) begin
      state_nxt = ST_IDLE;
      time_nxt  = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_PAUSED: begin
          if (time_load_en) begin
            time_nxt = time_load;
          end
          if (press_stop) begin
            // stop in IDLE does nothing; in PAUSED it abandons the cook
            if (state_q == ST_PAUSED) begin
              state_nxt = ST_IDLE;
              time_nxt  = '0;
            end
          end else if (press_start && door_closed && (time_q != '0)) begin
            state_nxt  = ST_COOK;
            cook_entry = 1'b1;
            phase_nxt  = '0;
          end
        end
        ST_COOK: begin
          // pausing wins over a coincident tick, which is simply dropped
          if (press_stop || !door_closed) begin
            state_nxt = ST_PAUSED;
          end else if (tick) begin
            phase_nxt = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
            if (time_q <= TIME_W'(1)) begin
              state_nxt = ST_DONE;
              time_nxt  = '0;
              done_nxt  = 1'b1;
            end else begin
              time_nxt = time_q - TIME_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (press_start || press_stop || !door_closed) begin
            state_nxt = ST_IDLE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

`ifdef MAGNETRON_BEEP_EN
  localparam int BW = $clog2(BEEP_TICKS + 1);

  logic [BW-1:0] beep_cnt;

  // done_nxt marks the edge into DONE; the counter then drains on DONE ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      beep_cnt <= '0;
    end else if (done_nxt) begin
      beep_cnt <= BW'(BEEP_TICKS);
    end else if ((state_q == ST_DONE) && tick && (beep_cnt != '0)) begin
      beep_cnt <= beep_cnt - 1'b1;
    end
  end

  assign beep    = (state_q == ST_DONE) && (beep_cnt != '0);
  assign tick_en = (state_q == ST_COOK) || (state_q == ST_DONE);
`else
  assign beep    = 1'b0;
  assign tick_en = (state_q == ST_COOK);
`endif

  assign mag_on    = (state_q == ST_COOK) && door_closed && (phase_q < power_q);
  assign time_left = time_q;
  assign state     = state_q;

endmodule

// File: tb/tb_magnetron_pwm_ctrl.sv
module tb_magnetron_pwm_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int TIME_W     = 8;
  localparam int PWR_LEVELS = 4;
  localparam int PW         = 3;

`ifdef MAGNETRON_BEEP_EN
  localparam int BEEP_CYC = 12;
  localparam int BEEP_AT5 = 1;
`else
  localparam int BEEP_CYC = 0;
  localparam int BEEP_AT5 = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              startn, stopn, clearn;
  logic              door_closed;
  logic [TIME_W-1:0] time_load;
  logic              time_load_en;
  logic [PW-1:0]     power_level;
  logic              mag_on;
  logic [TIME_W-1:0] time_left;
  logic [2:0]        state;
  logic              done;
  logic              beep;

  int n_chk = 0;
  int n_err = 0;

  magnetron_pwm_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .TIME_W     (TIME_W),
    .PWR_LEVELS (PWR_LEVELS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .startn       (startn),
    .stopn        (stopn),
    .clearn       (clearn),
    .door_closed  (door_closed),
    .time_load    (time_load),
    .time_load_en (time_load_en),
    .power_level  (power_level),
    .mag_on       (mag_on),
    .time_left    (time_left),
    .state        (state),
    .done         (done),
    .beep         (beep)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_time(input logic [TIME_W-1:0] v);
    time_load    = v;
    time_load_en = 1'b1;
    step(1);
    time_load_en = 1'b0;
  endtask

  // 0 = start, 1 = stop, 2 = clear; one edge with the button low
  task automatic press(input int which);
    case (which)
      0: startn = 1'b0;
      1: stopn  = 1'b0;
      default: clearn = 1'b0;
    endcase
    step(1);
    startn = 1'b1;
    stopn  = 1'b1;
    clearn = 1'b1;
  endtask

  int on_cnt, done_cnt, beep_cnt;

  initial begin
    rst = 1'b1;
    startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    door_closed = 1'b1;
    time_load = '0; time_load_en = 1'b0;
    power_level = '0;
    step(2);
    rst = 1'b0;
    chk("rst_state", state, 0);
    chk("rst_time", time_left, 0);
    chk("rst_mag", mag_on, 0);
    chk("rst_done", done, 0);
    chk("rst_beep", beep, 0);
    step(1);

    // load 3 s at full power, run to completion
    load_time(8'd3);
    chk("load3_time", time_left, 3);
    power_level = 3'd4;
    press(0);
    on_cnt = 0; done_cnt = 0; beep_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 0) chk("c1_enter", state, 1);
      if (i == 0) chk("c1_time3", time_left, 3);
      if (i == 4) chk("c1_time2", time_left, 2);
      if (i == 8) chk("c1_time1", time_left, 1);
      if (i == 12) chk("c1_time0", time_left, 0);
      if (i == 12) chk("c1_done_state", state, 3);
      if (i == 12) chk("c1_done_pulse", done, 1);
      on_cnt   += int'(mag_on);
      done_cnt += int'(done);
      beep_cnt += int'(beep);
      step(1);
    end
    chk("c1_on_cycles", on_cnt, 12);
    chk("c1_done_count", done_cnt, 1);
    chk("c1_beep_cycles", beep_cnt, BEEP_CYC);
    chk("c1_still_done", state, 3);
    door_closed = 1'b0;
    step(1);
    chk("done_door_idle", state, 0);
    door_closed = 1'b1;
    step(1);

    // 8 s at power 1: on for one tick of every four
    load_time(8'd8);
    power_level = 3'd1;
    press(0);
    for (int i = 0; i < 18; i++) begin
      chk("p1_pattern", mag_on, ((i / 4) % 4) == 0);
      step(1);
    end
    chk("p1_on_before_door", mag_on, 1);
    door_closed = 1'b0;
    #1;
    chk("door_mag_drop", mag_on, 0);
    chk("door_still_cook", state, 1);
    step(1);
    chk("door_paused", state, 2);
    chk("door_time_frozen", time_left, 4);
    step(5);
    chk("door_time_held", time_left, 4);
    chk("door_mag_off", mag_on, 0);
    door_closed = 1'b1;
    step(1);
    press(0);
    chk("resume_state", state, 1);
    chk("resume_time", time_left, 4);
    chk("resume_mag", mag_on, 1);
    step(4);
    chk("resume_tick", time_left, 3);

    // stop, stop, then refused starts
    press(1);
    chk("stop1_paused", state, 2);
    chk("stop1_time", time_left, 3);
    step(1);
    press(1);
    chk("stop2_idle", state, 0);
    chk("stop2_time", time_left, 0);
    step(1);
    press(0);
    chk("start_zero_time", state, 0);
    step(1);
    load_time(8'd5);
    door_closed = 1'b0;
    press(0);
    chk("start_door_open", state, 0);
    chk("start_door_time", time_left, 5);
    door_closed = 1'b1;
    step(1);

    // stop landing on a tick cycle: pause wins, tick dropped
    load_time(8'd2);
    power_level = 3'd4;
    press(0);
    step(3);
    press(1);
    chk("tick_stop_state", state, 2);
    chk("tick_stop_time", time_left, 2);
    step(1);

    // start + clear together in PAUSED
    startn = 1'b0;
    clearn = 1'b0;
    step(1);
    startn = 1'b1;
    clearn = 1'b1;
    chk("clr_start_state", state, 0);
    chk("clr_start_time", time_left, 0);
    step(1);

    // power above range saturates to full on
    load_time(8'd2);
    power_level = 3'd7;
    press(0);
    on_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      on_cnt += int'(mag_on);
      step(1);
    end
    chk("sat_on_cycles", on_cnt, 8);
    chk("sat_done_state", state, 3);
    press(2);
    chk("sat_clear_idle", state, 0);
    step(1);

    // power 0: magnetron stays off, countdown still completes
    load_time(8'd1);
    power_level = 3'd0;
    press(0);
    on_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      on_cnt += int'(mag_on);
      step(1);
    end
    chk("p0_on_cycles", on_cnt, 0);
    chk("p0_state", state, 3);
    chk("p0_done", done, 1);
    chk("p0_time", time_left, 0);
    step(1);
    chk("p0_done_once", done, 0);
    step(3);
    chk("beep_cycle5", beep, BEEP_AT5);
    press(1);
    chk("beep_press_idle", state, 0);
    chk("beep_press_off", beep, 0);
    step(1);

    // reset in the middle of cooking
    load_time(8'd5);
    power_level = 3'd4;
    press(0);
    step(2);
    chk("pre_rst_mag", mag_on, 1);
    rst = 1'b1;
    step(1);
    chk("mid_rst_state", state, 0);
    chk("mid_rst_time", time_left, 0);
    chk("mid_rst_mag", mag_on, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_beep", beep, 0);
    rst = 1'b0;
    step(2);
    chk("post_rst_idle", state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
